cp0_regfile: RTL and testbench

CP0_REGFILE -- requirements
Module: cp0_regfile

---
 rtl/cp0_regfile.sv | 204 ++++++++++++++++++++
 tb/tb_cp0_regfile.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// CP0 system-control register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Handles mtc0/mfc0 access, exception and eret commit, timer compare and interrupt request.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cp0_write_en/addr/data mtc0 commit ({rd,sel} address)
//   cp0_read_en/read_data  mfc0 read, combinational, no write bypass
//   exc_*                  exception commit from MEM
//   eret                   eret commit
//   int_hw                 external hardware interrupt levels
//   status/cause/epc       current register values
//   timer_int, int_pending Cause.TI and the interrupt-to-take request
module cp0_regfile #(
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
    parameter int unsigned COUNT_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_write_en,
    input  logic        cp0_read_en,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] cp0_write_data,
    output logic [31:0] cp0_read_data,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  int_hw,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        timer_int,
    output logic        int_pending
);

    localparam logic [7:0] A_BADVADDR = 8'h40;
    localparam logic [7:0] A_COUNT    = 8'h48;
    localparam logic [7:0] A_COMPARE  = 8'h58;
    localparam logic [7:0] A_STATUS   = 8'h60;
    localparam logic [7:0] A_CAUSE    = 8'h68;
    localparam logic [7:0] A_EPC      = 8'h70;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // BEV is not writable; it is fixed at its reset value.
    localparam logic BEV = STATUS_RESET[22];

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        phase_q, phase_d;

    logic        we;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        tick;
    logic [31:0] status_w;
    logic [31:0] cause_w;

    // mtc0 is squashed by a same-cycle exception.
    assign we         = cp0_write_en & ~exc_valid;
    assign wr_count   = we && (cp0_addr == A_COUNT);
    assign wr_compare = we && (cp0_addr == A_COMPARE);
    assign wr_status  = we && (cp0_addr == A_STATUS);
    assign wr_cause   = we && (cp0_addr == A_CAUSE);
    assign wr_epc     = we && (cp0_addr == A_EPC);

    // With a divide of 2 the count advances on the odd phase.
    assign tick = (COUNT_DIV == 1) ? 1'b1 : phase_q;

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        phase_d    = (COUNT_DIV == 1) ? 1'b0 : ~phase_q;

        // IP7 shares its pin with the timer interrupt.
        ip_hw_d = {int_hw[5] | ti_q, int_hw[4:0]};

        if (tick) begin
            count_d = count_q + 32'd1;
        end
        if (wr_count) begin
            count_d = cp0_write_data;
            phase_d = 1'b0;
        end

        // Compare write wins over a same-cycle match.
        if (wr_compare) begin
            compare_d = cp0_write_data;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end

        if (wr_cause) begin
            ip_sw_d = cp0_write_data[9:8];
        end

        if (wr_epc) begin
            epc_d = cp0_write_data;
        end

        if (exc_valid) begin
            exl_d     = 1'b1;
            exccode_d = exc_code;
            // A nested exception keeps the original return point.
            if (!exl_q) begin
                epc_d = exc_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                bd_d  = exc_delay_slot;
            end
            if ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES)) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (wr_status) begin
            im_d  = cp0_write_data[15:8];
            exl_d = cp0_write_data[1];
            ie_d  = cp0_write_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            epc_q      <= 32'd0;
            im_q       <= STATUS_RESET[15:8];
            exl_q      <= STATUS_RESET[1];
            ie_q       <= STATUS_RESET[0];
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
            exccode_q  <= 5'd0;
            phase_q    <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            phase_q    <= phase_d;
        end
    end

    assign status_w = {9'd0, BEV, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_w  = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q,
                       1'b0, exccode_q, 2'b00};

    always_comb begin
        cp0_read_data = 32'd0;
        if (cp0_read_en) begin
            case (cp0_addr)
                A_BADVADDR: cp0_read_data = badvaddr_q;
                A_COUNT:    cp0_read_data = count_q;
                A_COMPARE:  cp0_read_data = compare_q;
                A_STATUS:   cp0_read_data = status_w;
                A_CAUSE:    cp0_read_data = cause_w;
                A_EPC:      cp0_read_data = epc_q;
                default:    cp0_read_data = 32'd0;
            endcase
        end
    end

    assign status      = status_w;
    assign cause       = cause_w;
    assign epc         = epc_q;
    assign timer_int   = ti_q;
    assign int_pending = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (COUNT_DIV=2).
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp0_write_en;
    logic        cp0_read_en;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_write_data;
    logic [31:0] cp0_read_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  int_hw;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        timer_int;
    logic        int_pending;

    int n_assert = 0;
    int n_fail   = 0;

    cp0_regfile #(
        .STATUS_RESET(32'h0040_0000),
        .COUNT_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cp0_write_en(cp0_write_en),
        .cp0_read_en(cp0_read_en),
        .cp0_addr(cp0_addr),
        .cp0_write_data(cp0_write_data),
        .cp0_read_data(cp0_read_data),
        .exc_valid(exc_valid),
        .exc_code(exc_code),
        .exc_pc(exc_pc),
        .exc_delay_slot(exc_delay_slot),
        .exc_badvaddr(exc_badvaddr),
        .eret(eret),
        .int_hw(int_hw),
        .status(status),
        .cause(cause),
        .epc(epc),
        .timer_int(timer_int),
        .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        cp0_write_en   = 1'b1;
        cp0_addr       = a;
        cp0_write_data = d;
        tick();
        cp0_write_en   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        cp0_read_en = 1'b1;
        cp0_addr    = a;
        #1;
        d = cp0_read_data;
        cp0_read_en = 1'b0;
    endtask

    task automatic exc(input logic [4:0] c, input logic [31:0] pc,
                       input logic ds, input logic [31:0] bva);
        exc_valid      = 1'b1;
        exc_code       = c;
        exc_pc         = pc;
        exc_delay_slot = ds;
        exc_badvaddr   = bva;
        tick();
        exc_valid      = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        rst            = 1'b1;
        cp0_write_en   = 1'b0;
        cp0_read_en    = 1'b0;
        cp0_addr       = 8'h00;
        cp0_write_data = 32'd0;
        exc_valid      = 1'b0;
        exc_code       = 5'd0;
        exc_pc         = 32'd0;
        exc_delay_slot = 1'b0;
        exc_badvaddr   = 32'd0;
        eret           = 1'b0;
        int_hw         = 6'd0;
        tick();
        tick();
        rst = 1'b0;

        // Post-reset state
        chk("rst_status", status, 32'h0040_0000);
        chk("rst_cause", cause, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_ti", {31'd0, timer_int}, 32'd0);
        chk("rst_intp", {31'd0, int_pending}, 32'd0);
        rd(8'h40, v);
        chk("rst_badvaddr", v, 32'h0);
        rd(8'h48, v);
        chk("rst_count", v, 32'h0);
        rd(8'h08, v);
        chk("rd_unmapped", v, 32'h0);
        cp0_read_en = 1'b0;
        cp0_addr    = 8'h60;
        #1;
        chk("rd_disabled", cp0_read_data, 32'h0);

        // Timer compare
        mtc0(8'h48, 32'd5);
        mtc0(8'h58, 32'd8);
        chk("ti_cleared", {31'd0, timer_int}, 32'd0);
        mtc0(8'h60, 32'h0000_8001);
        chk("status_wr", status, 32'h0040_8001);
        v = 32'd0;
        for (int k = 0; k < 20; k++) begin
            rd(8'h48, v);
            if (v == 32'd8) break;
            tick();
        end
        chk("count_reach8", v, 32'd8);
        chk("ti_before", {31'd0, timer_int}, 32'd0);
        tick();
        chk("ti_set", {31'd0, timer_int}, 32'd1);
        chk("intp_lag", {31'd0, int_pending}, 32'd0);
        tick();
        chk("cause_ip7", {31'd0, cause[15]}, 32'd1);
        chk("intp_timer", {31'd0, int_pending}, 32'd1);
        tick();
        tick();
        chk("ti_sticky", {31'd0, timer_int}, 32'd1);

        // Exception with interrupt masked by EXL
        exc(5'd0, 32'hBFC0_0100, 1'b0, 32'h0);
        chk("exc_epc", epc, 32'hBFC0_0100);
        chk("exc_status", status, 32'h0040_8003);
        chk("exc_intp", {31'd0, int_pending}, 32'd0);
        mtc0(8'h58, 32'd20);
        chk("ti_clr20", {31'd0, timer_int}, 32'd0);
        mtc0(8'h58, 32'hFFFF_0000);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("eret1_status", status, 32'h0040_8001);

        // Delay-slot address error
        exc(5'd4, 32'h8000_0010, 1'b1, 32'h1234_5679);
        chk("ds_epc", epc, 32'h8000_000C);
        chk("ds_bd", {31'd0, cause[31]}, 32'd1);
        chk("ds_code", {27'd0, cause[6:2]}, 32'd4);
        rd(8'h40, v);
        chk("ds_bva", v, 32'h1234_5679);

        // Nested exception keeps EPC
        exc(5'd12, 32'h8000_0200, 1'b0, 32'hDEAD_BEEF);
        chk("nest_epc", epc, 32'h8000_000C);
        chk("nest_code", {27'd0, cause[6:2]}, 32'd12);
        chk("nest_bd", {31'd0, cause[31]}, 32'd1);
        rd(8'h40, v);
        chk("nest_bva", v, 32'h1234_5679);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("eret2_exl", {31'd0, status[1]}, 32'd0);

        // mtc0 dropped under exception
        cp0_write_en   = 1'b1;
        cp0_addr       = 8'h60;
        cp0_write_data = 32'h0;
        exc(5'd0, 32'h0000_0100, 1'b0, 32'h0);
        cp0_write_en   = 1'b0;
        chk("drop_status", status, 32'h0040_8003);
        chk("drop_epc", epc, 32'h0000_0100);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        mtc0(8'h68, 32'hFFFF_FFFF);
        chk("cause_mask", cause, 32'h0000_0300);
        mtc0(8'h40, 32'h0);
        rd(8'h40, v);
        chk("bva_ro", v, 32'h1234_5679);
        mtc0(8'h60, 32'h0000_0301);
        chk("status_sw", status, 32'h0040_0301);
        chk("intp_sw", {31'd0, int_pending}, 32'd1);
        mtc0(8'h60, 32'hFFFF_FFFF);
        chk("status_mask", status, 32'h0040_FF03);
        chk("intp_exl", {31'd0, int_pending}, 32'd0);
        int_hw = 6'b000001;
        tick();
        int_hw = 6'd0;
        chk("cause_hw0", cause, 32'h0000_0700);

        // Count wrap
        mtc0(8'h48, 32'hFFFF_FFFF);
        rd(8'h48, v);
        chk("wrap_load", v, 32'hFFFF_FFFF);
        tick();
        rd(8'h48, v);
        chk("wrap_hold", v, 32'hFFFF_FFFF);
        tick();
        rd(8'h48, v);
        chk("wrap_zero", v, 32'h0);

        // Reset mid-count and mid-exception
        tick();
        tick();
        tick();
        rst = 1'b1;
        exc(5'd4, 32'h0000_0123, 1'b0, 32'h5555_5555);
        rst = 1'b0;
        rd(8'h48, v);
        chk("rst2_count", v, 32'h0);
        chk("rst2_status", status, 32'h0040_0000);
        chk("rst2_epc", epc, 32'h0);
        rd(8'h40, v);
        chk("rst2_bva", v, 32'h0);

        // Compare write beats a same-cycle match
        mtc0(8'h58, 32'd50);
        chk("cmp_prio_ti", {31'd0, timer_int}, 32'd0);
        rd(8'h58, v);
        chk("cmp_prio_val", v, 32'd50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
